// File: rtl/fifo_arb_pkg.sv
// Shared types and constants for the fifo_syn write arbiter.
package fifo_arb_pkg;

   localparam int DEF_WIDTH = 8;
   localparam int DEF_DEPTH = 4;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } arb_state_e;

   function automatic int clog2(input int n);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < n) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/fifo_wr_arb_rr_pick.sv
// Combinational round-robin picker: first requester strictly after last_i.
module rr_pick
   import fifo_arb_pkg::*;
#(
   parameter int NREQ = 2,
   localparam int IW  = clog2(NREQ)
) (
   input  logic [NREQ-1:0] req_i,
   input  logic [IW-1:0]   last_i,
   output logic [NREQ-1:0] pick_o,
   output logic            valid_o
);

   logic [IW-1:0] idx;

   always_comb begin
      pick_o  = '0;
      valid_o = 1'b0;
      idx     = '0;
      for (int k = 1; k <= NREQ; k++) begin
         idx = IW'((int'(last_i) + k) % NREQ);
         if (!valid_o && req_i[idx]) begin
            pick_o[idx] = 1'b1;
            valid_o     = 1'b1;
         end
      end
   end

endmodule

// File: rtl/fifo_wr_arb.sv
// Round-robin write arbiter in front of fifo_syn with an occupancy credit counter.
//  state   | meaning
//  ST_IDLE | no owner; pick next requester, register its grant
//  ST_BUSY | owner holds grant; accept words while credit, up to BURST
module fifo_wr_arb
   import fifo_arb_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int NREQ  = 2,
   parameter int BURST = 4,
   parameter int DEPTH = DEF_DEPTH
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NREQ-1:0]       req,
   input  logic [NREQ*WIDTH-1:0] din,
   output logic [NREQ-1:0]       ack,
   output logic [NREQ-1:0]       gnt,
   input  logic                  fifo_rd,
   input  logic                  fifo_empty,
   output logic                  fifo_wr,
   output logic [WIDTH-1:0]      fifo_data
);

   localparam int IW = clog2(NREQ);
   localparam int OW = clog2(DEPTH + 1);
   localparam int BW = clog2(BURST + 1);

   arb_state_e       state_q, state_d;
   logic [NREQ-1:0]  gnt_q, gnt_d;
   logic [IW-1:0]    owner_q, owner_d;
   logic [IW-1:0]    last_q, last_d;
   logic [BW-1:0]    burst_q, burst_d;
   logic [OW-1:0]    occ_q, occ_d;
   logic             wr_q, wr_d;
   logic [WIDTH-1:0] data_q, data_d;

   logic [NREQ-1:0]  pick;
   logic             pick_valid;
   logic [IW-1:0]    pick_idx;
   logic             credit;
   logic             accept;
   logic             dec;

   rr_pick #(.NREQ(NREQ)) u_pick (
      .req_i   (req),
      .last_i  (last_q),
      .pick_o  (pick),
      .valid_o (pick_valid)
   );

   always_comb begin
      pick_idx = '0;
      for (int k = 0; k < NREQ; k++) begin
         if (pick[k]) pick_idx = IW'(k);
      end
   end

   // Credit comes from the registered count only, so a read frees a slot next cycle.
   assign credit = (occ_q < OW'(DEPTH));
   assign dec    = fifo_rd & ~fifo_empty;

   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      owner_d = owner_q;
      last_d  = last_q;
      burst_d = burst_q;
      wr_d    = 1'b0;
      data_d  = data_q;
      accept  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (pick_valid) begin
               gnt_d   = pick;
               owner_d = pick_idx;
               burst_d = '0;
               state_d = ST_BUSY;
            end
         end
         ST_BUSY: begin
            accept = req[owner_q] & credit;
            if (accept) begin
               data_d  = din[int'(owner_q)*WIDTH +: WIDTH];
               wr_d    = 1'b1;
               burst_d = burst_q + BW'(1);
            end
            if (!req[owner_q] || (accept && (burst_q == BW'(BURST - 1)))) begin
               gnt_d   = '0;
               last_d  = owner_q;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      occ_d = occ_q;
      if (accept && !dec)      occ_d = occ_q + OW'(1);
      else if (!accept && dec) occ_d = occ_q - OW'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         gnt_q   <= '0;
         owner_q <= '0;
         last_q  <= IW'(NREQ - 1);
         burst_q <= '0;
         occ_q   <= '0;
         wr_q    <= 1'b0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         owner_q <= owner_d;
         last_q  <= last_d;
         burst_q <= burst_d;
         occ_q   <= occ_d;
         wr_q    <= wr_d;
         data_q  <= data_d;
      end
   end

   assign ack       = gnt_q & {NREQ{accept}};
   assign gnt       = gnt_q;
   assign fifo_wr   = wr_q;
   assign fifo_data = data_q;

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Scoreboard bench for fifo_wr_arb with a behavioural fifo_syn occupancy model.
module tb_fifo_wr_arb;

   localparam int W = 8;
   localparam int N = 2;
   localparam int B = 4;
   localparam int D = 4;

   logic           clk = 1'b0;
   logic           rst;
   logic [N-1:0]   req;
   logic [N*W-1:0] din;
   logic [N-1:0]   ack;
   logic [N-1:0]   gnt;
   logic           fifo_rd;
   logic           fifo_empty;
   logic           fifo_wr;
   logic [W-1:0]   fifo_data;

   always #5 clk = ~clk;

   fifo_wr_arb #(.WIDTH(W), .NREQ(N), .BURST(B), .DEPTH(D)) dut (
      .clk        (clk),
      .rst        (rst),
      .req        (req),
      .din        (din),
      .ack        (ack),
      .gnt        (gnt),
      .fifo_rd    (fifo_rd),
      .fifo_empty (fifo_empty),
      .fifo_wr    (fifo_wr),
      .fifo_data  (fifo_data)
   );

   int checks   = 0;
   int failures = 0;

   logic [7:0] q0[$];
   logic [7:0] q1[$];
   logic [7:0] exp_q[$];
   logic [1:0] req_en;
   int         occ_m;
   int         fcnt;
   int         wr_run;

   logic [1:0] s_ack;
   logic [1:0] s_gnt;
   logic       s_wr;
   logic [7:0] s_data;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic drive();
      din        = {(q1.size() > 0) ? q1[0] : 8'h00, (q0.size() > 0) ? q0[0] : 8'h00};
      req        = {req_en[1] && (q1.size() > 0), req_en[0] && (q0.size() > 0)};
      fifo_empty = (fcnt == 0);
   endtask

   task automatic cycle();
      @(negedge clk);
      s_ack  = ack;
      s_gnt  = gnt;
      s_wr   = fifo_wr;
      s_data = fifo_data;
      if (!rst) begin
         if (s_ack != 2'b00) chk("ack_matches_gnt", 32'(s_gnt), 32'(s_ack));
         if (occ_m >= D) chk("ack_without_credit", 32'(s_ack), 32'h0);
         if (s_wr) begin
            if (exp_q.size() == 0) chk("wr_unexpected", 32'(s_wr), 32'h0);
            else                   chk("wr_data", 32'(s_data), 32'(exp_q.pop_front()));
         end
      end
      if (s_ack[0] && q0.size() > 0) exp_q.push_back(q0.pop_front());
      if (s_ack[1] && q1.size() > 0) exp_q.push_back(q1.pop_front());
      if (s_ack != 2'b00) occ_m++;
      if (fifo_rd && !fifo_empty) begin
         occ_m--;
         fcnt--;
      end
      if (s_wr) fcnt++;
      @(posedge clk);
      #1;
      drive();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      q0.delete();
      q1.delete();
      exp_q.delete();
      occ_m  = 0;
      fcnt   = 0;
      req_en = 2'b00;
      drive();
      cycle();
      cycle();
      rst = 1'b0;
      drive();
   endtask

   task automatic drain();
      bit done;
      done = 1'b0;
      for (int i = 0; i < 60 && !done; i++) begin
         cycle();
         done = (s_gnt == 2'b00) && (occ_m == 0) && (fcnt == 0) &&
                (exp_q.size() == 0) && (req == '0);
      end
      chk("drain_timeout", 32'(done), 32'h1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [1:0] e;
      rst     = 1'b1;
      fifo_rd = 1'b0;
      occ_m   = 0;
      fcnt    = 0;
      wr_run  = 0;
      req_en  = 2'b11;
      q0.push_back(8'hA1);
      q1.push_back(8'hB1);
      drive();
      @(posedge clk);
      #1;

      // 1: reset holds everything quiet with both requests up
      for (int i = 0; i < 3; i++) begin
         cycle();
         chk("t1_gnt", 32'(s_gnt), 32'h0);
         chk("t1_ack", 32'(s_ack), 32'h0);
         chk("t1_wr", 32'(s_wr), 32'h0);
         chk("t1_data", 32'(s_data), 32'h0);
      end
      rst = 1'b0;
      cycle();
      chk("t1_idle_gnt", 32'(s_gnt), 32'h0);
      cycle();
      chk("t1_first_gnt", 32'(s_gnt), 32'h1);
      chk("t1_first_ack", 32'(s_ack), 32'h1);

      // 2: single requester fills the FIFO in one burst
      do_reset();
      req_en = 2'b01;
      q0 = '{8'h12, 8'h34, 8'h56, 8'h78};
      drive();
      cycle();
      chk("t2_idle", 32'(s_gnt), 32'h0);
      for (int i = 0; i < 4; i++) begin
         cycle();
         chk("t2_gnt", 32'(s_gnt), 32'h1);
         chk("t2_ack", 32'(s_ack), 32'h1);
      end
      cycle();
      chk("t2_release", 32'(s_gnt), 32'h0);
      chk("t2_last_wr", 32'(s_wr), 32'h1);

      // 4: full FIFO, credit returned by single reads
      req_en = 2'b10;
      q1 = '{8'h9A, 8'hBC, 8'hDE, 8'hF0};
      drive();
      cycle();
      chk("t4_idle_ack", 32'(s_ack), 32'h0);
      cycle();
      chk("t4_gnt", 32'(s_gnt), 32'h2);
      chk("t4_hold", 32'(s_ack), 32'h0);
      cycle();
      chk("t4_hold2", 32'(s_ack), 32'h0);
      fifo_rd = 1'b1;
      cycle();
      chk("t4_credit_same_cycle", 32'(s_ack), 32'h0);
      fifo_rd = 1'b0;
      cycle();
      chk("t4_one_ack", 32'(s_ack), 32'h2);
      cycle();
      chk("t4_full_again", 32'(s_ack), 32'h0);
      fifo_rd = 1'b1;
      cycle();
      chk("t4_rd_only", 32'(s_ack), 32'h0);
      cycle();
      chk("t4_rd_and_ack", 32'(s_ack), 32'h2);
      fifo_rd = 1'b0;
      cycle();
      chk("t4_occ_const", 32'(s_ack), 32'h2);
      cycle();
      chk("t4_full_final", 32'(s_ack), 32'h0);
      fifo_rd = 1'b1;
      drain();

      // 5: owner drops early, next grant gets a fresh burst
      req_en = 2'b11;
      q0 = '{8'h11, 8'h22};
      q1 = '{8'h33, 8'h44, 8'h55, 8'h66};
      drive();
      cycle();
      chk("t5_idle", 32'(s_gnt), 32'h0);
      for (int i = 0; i < 2; i++) begin
         cycle();
         chk("t5_ack0", 32'(s_ack), 32'h1);
      end
      cycle();
      chk("t5_drop_gnt", 32'(s_gnt), 32'h1);
      chk("t5_drop_ack", 32'(s_ack), 32'h0);
      cycle();
      chk("t5_bubble", 32'(s_gnt), 32'h0);
      for (int i = 0; i < 4; i++) begin
         cycle();
         chk("t5_ack1", 32'(s_ack), 32'h2);
      end
      cycle();
      chk("t5_release", 32'(s_gnt), 32'h0);

      // 3: both requesting with continuous reads alternate 4-word bursts
      req_en = 2'b11;
      q0.delete();
      q1.delete();
      for (int i = 0; i < 10; i++) begin
         q0.push_back(8'(i));
         q1.push_back(8'(8'h80 + i));
      end
      drive();
      wr_run = 0;
      for (int c = 0; c < 15; c++) begin
         cycle();
         e = ((c % 5) == 0) ? 2'b00 : ((((c / 5) % 2) == 0) ? 2'b01 : 2'b10);
         chk("t3_gnt", 32'(s_gnt), 32'(e));
         chk("t3_ack", 32'(s_ack), 32'(e));
         wr_run = s_wr ? wr_run + 1 : 0;
         if (s_wr) chk("t3_wr_run", 32'(wr_run > B), 32'h0);
      end
      req_en = 2'b00;
      drive();
      drain();

      // 6: reset mid-burst clears grant, strobe and credit count
      fifo_rd = 1'b0;
      req_en  = 2'b01;
      q0 = '{8'hC1, 8'hC2, 8'hC3, 8'hC4};
      drive();
      cycle();
      cycle();
      cycle();
      rst = 1'b1;
      #1;
      chk("t6_gnt", 32'(gnt), 32'h0);
      chk("t6_ack", 32'(ack), 32'h0);
      chk("t6_wr", 32'(fifo_wr), 32'h0);
      chk("t6_data", 32'(fifo_data), 32'h0);
      q0.delete();
      exp_q.delete();
      occ_m  = 0;
      fcnt   = 0;
      req_en = 2'b00;
      drive();
      cycle();
      rst    = 1'b0;
      req_en = 2'b11;
      q0 = '{8'hD1, 8'hD2, 8'hD3, 8'hD4};
      q1 = '{8'hE1, 8'hE2, 8'hE3, 8'hE4};
      drive();
      cycle();
      chk("t6_idle", 32'(s_gnt), 32'h0);
      for (int i = 0; i < 4; i++) begin
         cycle();
         chk("t6_ack0", 32'(s_ack), 32'h1);
      end
      cycle();
      chk("t6_bubble", 32'(s_gnt), 32'h0);
      cycle();
      chk("t6_gnt1", 32'(s_gnt), 32'h2);
      chk("t6_full", 32'(s_ack), 32'h0);
      cycle();
      chk("sb_empty", 32'(exp_q.size()), 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
